frame_sequencer: RTL and testbench

- Control block ahead of the grayscale -> Sobel -> threshold -> connected-components pixel pipeline.
- Gates the pipeline's global `en`, and generates `hsync`/`vsync` for the location generator.
- Applies backpressure to the pixel source and stalls on the output sink.
- Drains the line-buffer latency at end of frame, and marks which enabled cycles carry a valid output pixel, with output coordinates and frame framing.

---
 rtl/frame_sequencer.sv | 167 ++++++++++++++++
 tb/tb_frame_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// Frame sequencer: gates the pixel pipeline enable, generates sync for the location
// generator, drains the line-buffer latency and tags valid output pixels with coordinates.
module frame_sequencer #(
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int LATENCY      = FRAME_WIDTH + 2,
    parameter int CNT_W        = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in_sof,
    output logic        in_ready,
    input  logic        out_ready,
    output logic        en,
    output logic        pad,
    output logic        hsync,
    output logic        vsync,
    output logic        out_valid,
    output logic        out_sof,
    output logic        out_eol,
    output logic [10:0] out_x,
    output logic [10:0] out_y,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic [15:0] drop_count,
    output logic        sof_err
);

    localparam logic [10:0]      X_LAST   = 11'(FRAME_WIDTH - 1);
    localparam logic [10:0]      Y_LAST   = 11'(FRAME_HEIGHT - 1);
    localparam logic [CNT_W-1:0] LAT      = CNT_W'(LATENCY);
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t           r_state;
    logic [10:0]      r_in_x, r_in_y, r_out_x, r_out_y;
    logic [CNT_W-1:0] r_fill, r_drain;
    logic [15:0]      r_frame_count, r_drop_count;
    logic             r_sof_err;

    logic w_start, w_in_ready, w_en, w_pad, w_hsync, w_vsync, w_done, w_out_valid;

    // Everything seen by the pipeline is decoded from state; reset masks it all off.
    always_comb begin
        w_start    = 1'b0;
        w_in_ready = 1'b0;
        w_en       = 1'b0;
        w_pad      = 1'b0;
        w_hsync    = 1'b0;
        w_vsync    = 1'b0;
        w_done     = 1'b0;
        if (!reset) begin
            case (r_state)
                S_IDLE: begin
                    w_start    = in_valid & in_sof;
                    w_in_ready = ~(w_start & ~out_ready);
                    w_en       = w_start & out_ready;
                    w_hsync    = w_en;
                    w_vsync    = w_en;
                end
                S_RUN: begin
                    w_in_ready = out_ready;
                    w_en       = in_valid & out_ready;
                    w_hsync    = w_en & (r_in_x == '0);
                end
                S_DRAIN: begin
                    w_pad = 1'b1;
                    w_en  = out_ready;
                end
                S_DONE: w_done = 1'b1;
                default: ;
            endcase
        end
    end

    assign w_out_valid = w_en & (r_fill == LAT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_in_x        <= '0;
            r_in_y        <= '0;
            r_out_x       <= '0;
            r_out_y       <= '0;
            r_fill        <= '0;
            r_drain       <= '0;
            r_frame_count <= '0;
            r_drop_count  <= '0;
            r_sof_err     <= 1'b0;
        end else begin
            if (w_en) begin
                if (r_fill != LAT)
                    r_fill <= r_fill + 1'b1;
                if (r_state != S_DRAIN) begin
                    if (r_in_x == X_LAST) begin
                        r_in_x <= '0;
                        r_in_y <= (r_in_y == Y_LAST) ? '0 : r_in_y + 1'b1;
                    end else begin
                        r_in_x <= r_in_x + 1'b1;
                    end
                end
            end
            if (w_out_valid) begin
                if (r_out_x == X_LAST) begin
                    r_out_x <= '0;
                    r_out_y <= (r_out_y == Y_LAST) ? '0 : r_out_y + 1'b1;
                end else begin
                    r_out_x <= r_out_x + 1'b1;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (in_valid && !in_sof && (r_drop_count != '1))
                        r_drop_count <= r_drop_count + 1'b1;
                    if (w_en)
                        r_state <= S_RUN;
                end
                S_RUN: begin
                    if (w_en) begin
                        if (in_sof)
                            r_sof_err <= 1'b1;
                        if (r_in_x == X_LAST && r_in_y == Y_LAST)
                            r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_en) begin
                        if (r_drain == LAT_LAST) begin
                            r_drain <= '0;
                            r_state <= S_DONE;
                        end else begin
                            r_drain <= r_drain + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_frame_count <= r_frame_count + 1'b1;
                    r_in_x        <= '0;
                    r_in_y        <= '0;
                    r_out_x       <= '0;
                    r_out_y       <= '0;
                    r_fill        <= '0;
                    r_state       <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = w_in_ready;
    assign en          = w_en;
    assign pad         = w_pad;
    assign hsync       = w_hsync;
    assign vsync       = w_vsync;
    assign out_valid   = w_out_valid;
    assign out_sof     = w_out_valid & (r_out_x == '0) & (r_out_y == '0);
    assign out_eol     = w_out_valid & (r_out_x == X_LAST);
    assign out_x       = r_out_x;
    assign out_y       = r_out_y;
    assign frame_done  = w_done;
    assign frame_count = r_frame_count;
    assign drop_count  = r_drop_count;
    assign sof_err     = r_sof_err;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer on an 8x4 frame with a 10-cycle pipeline latency.
module tb_frame_sequencer;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_sof, in_ready, out_ready;
    logic        en, pad, hsync, vsync, out_valid, out_sof, out_eol, frame_done, sof_err;
    logic [10:0] out_x, out_y;
    logic [15:0] frame_count, drop_count;

    int checks = 0;
    int errors = 0;

    frame_sequencer #(
        .FRAME_WIDTH (8),
        .FRAME_HEIGHT(4),
        .LATENCY     (10),
        .CNT_W       (12)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_ready   (in_ready),
        .out_ready  (out_ready),
        .en         (en),
        .pad        (pad),
        .hsync      (hsync),
        .vsync      (vsync),
        .out_valid  (out_valid),
        .out_sof    (out_sof),
        .out_eol    (out_eol),
        .out_x      (out_x),
        .out_y      (out_y),
        .frame_done (frame_done),
        .frame_count(frame_count),
        .drop_count (drop_count),
        .sof_err    (sof_err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Feeds one 32-pixel frame and checks the output stream against an index-derived model.
    task automatic run_frame(input string tag, input bit gap, input int stall_at,
                             input int sof_at, input int exp_fc);
        int p = 0, cyc = 0, n_en = 0, n_ov = 0, n_eol = 0, n_sof = 0, n_pad = 0;
        int first_ov_en = -1, first_sof = 0, run = 0, max_run = 0;
        int last_en_cyc = -1, done_cyc = -1, bad_xy = 0, bad_sync = 0;
        int stall_left = 5, bad_stall = 0;
        logic [31:0] hs_mask = '0;
        logic [31:0] vs_mask = '0;
        bit stalling;
        while (done_cyc < 0 && cyc < 300) begin
            stalling  = (stall_at >= 0) && (p == stall_at) && (stall_left > 0);
            in_valid  = (p < 32) ? (gap ? (cyc % 2 == 0) : 1'b1) : 1'b0;
            in_sof    = in_valid && (p == 0 || p == sof_at);
            out_ready = !stalling;
            @(negedge clk);
            if (stalling) begin
                if (in_ready !== 1'b0 || en !== 1'b0 || out_valid !== 1'b0)
                    bad_stall++;
                stall_left--;
            end
            if (int'(out_x) != n_ov % 8 || int'(out_y) != (n_ov / 8) % 4)
                bad_xy++;
            if ((hsync || vsync) && !en)
                bad_sync++;
            if (pad) n_pad++;
            if (en) begin
                n_en++;
                run++;
                if (run > max_run) max_run = run;
                last_en_cyc = cyc;
                if (p < 32) begin
                    if (hsync) hs_mask[p] = 1'b1;
                    if (vsync) vs_mask[p] = 1'b1;
                end else if (hsync || vsync) begin
                    bad_sync++;
                end
            end else begin
                run = 0;
            end
            if (out_valid) begin
                if (n_ov == 0) begin
                    first_ov_en = n_en;
                    first_sof   = int'(out_sof);
                end
                if (out_sof) n_sof++;
                if (out_eol) begin
                    n_eol++;
                    if (out_x != 11'd7) bad_xy++;
                end
                n_ov++;
            end
            if (frame_done) done_cyc = cyc;
            if (in_valid && in_ready) p++;
            next_cycle();
            cyc++;
        end
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        out_ready = 1'b1;
        chk({tag, "_frame_done_seen"}, int'(done_cyc >= 0), 1);
        chk({tag, "_pixels_accepted"}, p, 32);
        chk({tag, "_en_cycles"}, n_en, 42);
        chk({tag, "_pad_cycles"}, n_pad, 10);
        chk({tag, "_first_out_en_idx"}, first_ov_en, 11);
        chk({tag, "_first_out_sof"}, first_sof, 1);
        chk({tag, "_sof_count"}, n_sof, 1);
        chk({tag, "_out_valid_count"}, n_ov, 32);
        chk({tag, "_eol_count"}, n_eol, 4);
        chk({tag, "_coord_errors"}, bad_xy, 0);
        chk({tag, "_sync_errors"}, bad_sync, 0);
        chk({tag, "_hsync_mask"}, int'(hs_mask), 32'h01010101);
        chk({tag, "_vsync_mask"}, int'(vs_mask), 1);
        chk({tag, "_done_after_last_en"}, done_cyc, last_en_cyc + 1);
        if (!gap && stall_at < 0)
            chk({tag, "_en_run_length"}, max_run, 42);
        if (stall_at >= 0)
            chk({tag, "_stall_errors"}, bad_stall, 0);
        chk({tag, "_frame_count"}, int'(frame_count), exp_fc);
    endtask

    typedef struct {
        logic v, s, r;
        logic exp_rdy, exp_en, exp_hs, exp_vs;
        int   exp_drop;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3};

        reset     = 1'b1;
        in_valid  = 1'b1;
        in_sof    = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_en", int'(en), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_sync", int'(hsync | vsync), 0);
        chk("rst_out_valid", int'(out_valid | pad | frame_done), 0);
        next_cycle();
        next_cycle();
        reset    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        #1;
        chk("post_rst_frame_count", int'(frame_count), 0);
        chk("post_rst_drop_count", int'(drop_count), 0);
        chk("post_rst_sof_err", int'(sof_err), 0);
        chk("post_rst_out_xy", int'({out_x, out_y}), 0);

        for (int i = 0; i < 6; i++) begin
            in_valid  = tbl[i].v;
            in_sof    = tbl[i].s;
            out_ready = tbl[i].r;
            @(negedge clk);
            chk($sformatf("idle%0d_in_ready", i), int'(in_ready), int'(tbl[i].exp_rdy));
            chk($sformatf("idle%0d_en", i), int'(en), int'(tbl[i].exp_en));
            chk($sformatf("idle%0d_sync", i), int'({hsync, vsync}),
                int'({tbl[i].exp_hs, tbl[i].exp_vs}));
            next_cycle();
            chk($sformatf("idle%0d_drop_count", i), int'(drop_count), tbl[i].exp_drop);
        end
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        out_ready = 1'b1;

        run_frame("cont", 1'b0, -1, -1, 1);
        run_frame("stall", 1'b0, 12, -1, 2);
        run_frame("gap", 1'b1, -1, -1, 3);
        chk("sof_err_clear_before", int'(sof_err), 0);
        run_frame("midsof", 1'b0, -1, 10, 4);
        chk("sof_err_after_midsof", int'(sof_err), 1);
        run_frame("after_sof", 1'b0, -1, -1, 5);
        chk("sof_err_sticky", int'(sof_err), 1);
        chk("drop_count_kept", int'(drop_count), 3);

        // Reset landing in the middle of the drain phase.
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1;
            in_sof   = (i == 0);
            next_cycle();
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("drain%0d_pad_en", i), int'({pad, en}), 3);
            next_cycle();
        end
        reset = 1'b1;
        @(negedge clk);
        chk("drain_rst_en_pad", int'({en, pad}), 0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("drain_rst_frame_count", int'(frame_count), 0);
        chk("drain_rst_en_pad_after", int'({en, pad}), 0);
        chk("drain_rst_idle_ready", int'(in_ready), 1);
        chk("drain_rst_sof_err", int'(sof_err), 0);
        chk("drain_rst_out_xy", int'({out_x, out_y}), 0);
        next_cycle();
        run_frame("post_rst", 1'b0, -1, -1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
